// File: rtl/regfile_scrub_mp.sv
// Integer register file: NRD combinational read ports, one write port, x0 hardwired to zero,
// plus a one-register-per-cycle scrub engine. Optional write-through: REGFILE_BYPASS_EN.
module regfile_scrub_mp #(
  parameter int unsigned  XLEN  = 32,
  parameter int unsigned  NREGS = 32,
  parameter int unsigned  NRD   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                regwrite_i,
  input  logic [AW-1:0]       rd_i,
  input  logic [XLEN-1:0]     wd_i,
  output logic                wr_ready_o,
  input  logic [NRD*AW-1:0]   rs_i,
  output logic [NRD*XLEN-1:0] operand_o,
  input  logic                clr_i,
  output logic                busy_o,
  output logic                clr_done_o
);

  typedef enum logic {StIdle, StScrub} state_e;

  localparam logic [AW-1:0] LastIdx  = AW'(NREGS - 1);
  localparam logic [AW-1:0] FirstIdx = AW'(1);

  state_e          r_state;
  state_e          w_state_next;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_next;
  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_we;

  // Entry 0 is never written; reads of index 0 are forced to zero regardless.
  assign w_we = regwrite_i && (r_state == StIdle) && (rd_i != '0);

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    busy_o       = 1'b0;
    clr_done_o   = 1'b0;
    wr_ready_o   = 1'b0;
    unique case (r_state)
      StIdle: begin
        wr_ready_o = 1'b1;
        if (clr_i) begin
          w_state_next = StScrub;
          w_idx_next   = FirstIdx;
        end
      end
      StScrub: begin
        busy_o = 1'b1;
        if (r_idx == LastIdx) begin
          clr_done_o   = 1'b1;
          w_state_next = StIdle;
          w_idx_next   = FirstIdx;
        end else begin
          w_idx_next = r_idx + AW'(1);
        end
      end
      default: begin
        w_state_next = StIdle;
        w_idx_next   = FirstIdx;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= StIdle;
      r_idx   <= FirstIdx;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Scrub and writeback never collide: writes are only accepted in StIdle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_state == StScrub) begin
      r_regs[r_idx] <= '0;
    end else if (w_we) begin
      r_regs[rd_i] <= wd_i;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_rs;
    assign w_rs = rs_i[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign operand_o[k*XLEN +: XLEN] = (w_rs == '0)             ? '0   :
                                       (w_we && (w_rs == rd_i)) ? wd_i :
                                                                  r_regs[w_rs];
`else
    assign operand_o[k*XLEN +: XLEN] = (w_rs == '0) ? '0 : r_regs[w_rs];
`endif
  end

endmodule

// File: tb/tb_regfile_scrub_mp.sv
// Directed bench for regfile_scrub_mp: vector table for reads/writes, hand sequences for
// scrub length, write drop during scrub, and reset in the middle of a scrub.
module tb_regfile_scrub_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;

  logic                clk = 1'b0;
  logic                reset_i;
  logic                regwrite_i;
  logic [AW-1:0]       rd_i;
  logic [XLEN-1:0]     wd_i;
  logic                wr_ready_o;
  logic [NRD*AW-1:0]   rs_i;
  logic [NRD*XLEN-1:0] operand_o;
  logic                clr_i;
  logic                busy_o;
  logic                clr_done_o;

  regfile_scrub_mp #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .NRD  (NRD)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .regwrite_i(regwrite_i),
    .rd_i      (rd_i),
    .wd_i      (wd_i),
    .wr_ready_o(wr_ready_o),
    .rs_i      (rs_i),
    .operand_o (operand_o),
    .clr_i     (clr_i),
    .busy_o    (busy_o),
    .clr_done_o(clr_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        f0;  // with write-through, op0 expects wd
    logic        f1;
  } vec_t;

  vec_t vt [8];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic [4:0] rs0, input logic [4:0] rs1);
    regwrite_i = we;
    rd_i       = rd;
    wd_i       = wd;
    rs_i       = {rs1, rs0};
  endtask

  task automatic chk_ctl(input string name, input logic busy, input logic ready,
                         input logic done);
    chk({name, ".busy"}, {31'd0, busy_o}, {31'd0, busy});
    chk({name, ".ready"}, {31'd0, wr_ready_o}, {31'd0, ready});
    chk({name, ".done"}, {31'd0, clr_done_o}, {31'd0, done});
  endtask

  initial begin
    logic [31:0] e0;
    logic [31:0] e1;
    int          n;
    int          done_cnt;
    int          done_at;

    vt[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 32'h0,         32'h0,         1'b1, 1'b0};
    vt[1] = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0};
    vt[2] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};
    vt[3] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd5, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};
    vt[4] = '{1'b1, 5'd7, 32'h1234,      5'd7, 5'd5, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0};
    vt[5] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd7, 32'h1234,      32'h1234,      1'b0, 1'b0};
    vt[6] = '{1'b1, 5'd5, 32'hA5A5_A5A5, 5'd5, 5'd7, 32'hDEAD_BEEF, 32'h1234,      1'b1, 1'b0};
    vt[7] = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd1, 32'hA5A5_A5A5, 32'h0,         1'b0, 1'b0};

    reset_i = 1'b1;
    clr_i   = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    reset_i = 1'b0;

    // Reset state: every register reads zero, engine idle.
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
      @(negedge clk);
      chk($sformatf("rst.op0[%0d]", i), operand_o[31:0], 32'h0);
      chk($sformatf("rst.op1[%0d]", i), operand_o[63:32], 32'h0);
      if (i == 1) chk_ctl("rst", 1'b0, 1'b1, 1'b0);
      tick();
    end

    for (int v = 0; v < 8; v++) begin
      drive(vt[v].we, vt[v].rd, vt[v].wd, vt[v].rs0, vt[v].rs1);
      e0 = vt[v].e0;
      e1 = vt[v].e1;
`ifdef REGFILE_BYPASS_EN
      if (vt[v].f0) e0 = vt[v].wd;
      if (vt[v].f1) e1 = vt[v].wd;
`endif
      @(negedge clk);
      chk($sformatf("vec%0d.op0", v), operand_o[31:0], e0);
      chk($sformatf("vec%0d.op1", v), operand_o[63:32], e1);
      chk_ctl($sformatf("vec%0d", v), 1'b0, 1'b1, 1'b0);
      tick();
    end

    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
      tick();
    end
    for (int i = 1; i < 32; i += 5) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
      @(negedge clk);
      chk($sformatf("fill.op0[%0d]", i), operand_o[31:0], 32'(i));
      chk($sformatf("fill.op1[%0d]", i), operand_o[63:32], 32'(32 - i));
      tick();
    end

    // Scrub: clr_i held for a while to show it is ignored mid-scrub; rd=3 write dropped.
    clr_i = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    chk_ctl("clr.req", 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 31; c++) begin
      tick();
      clr_i = (c <= 20);
      drive(1'b1, 5'd3, 32'hFFFF_FFFF, 5'(c), 5'(c - 1));
      @(negedge clk);
      chk_ctl($sformatf("scrub%0d", c), 1'b1, 1'b0, c == 31);
      chk($sformatf("scrub%0d.op0", c), operand_o[31:0], 32'(c));
      chk($sformatf("scrub%0d.op1", c), operand_o[63:32], 32'h0);
    end
    tick();
    clr_i = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd31);
    @(negedge clk);
    chk_ctl("scrub.end", 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
      @(negedge clk);
      chk($sformatf("clr.op0[%0d]", i), operand_o[31:0], 32'h0);
      tick();
    end

    drive(1'b1, 5'd3, 32'd77, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    @(negedge clk);
    chk("post.wr3", operand_o[31:0], 32'd77);

    // Reset in the middle of a scrub.
    tick();
    drive(1'b1, 5'd9, 32'd99, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd31, 32'h31, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd9);
    clr_i = 1'b1;
    @(negedge clk);
    chk("mid.op0", operand_o[31:0], 32'h31);
    chk("mid.op1", operand_o[63:32], 32'd99);
    for (int c = 1; c <= 10; c++) begin
      tick();
      clr_i = 1'b0;
      @(negedge clk);
      chk($sformatf("mid%0d.busy", c), {31'd0, busy_o}, 32'd1);
    end
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    @(negedge clk);
    chk_ctl("mid.rst", 1'b0, 1'b1, 1'b0);
    chk("mid.rst.op0", operand_o[31:0], 32'h0);
    chk("mid.rst.op1", operand_o[63:32], 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd30);
    #1;
    chk("mid.rst.r3", operand_o[31:0], 32'h0);

    // Fresh scrub after reset must run the full length.
    tick();
    clr_i    = 1'b1;
    n        = 0;
    done_cnt = 0;
    done_at  = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      clr_i = 1'b0;
      @(negedge clk);
      if (!busy_o) break;
      n++;
      if (clr_done_o) begin
        done_cnt++;
        done_at = n;
      end
    end
    chk("rescrub.len", 32'(n), 32'd31);
    chk("rescrub.done_cnt", 32'(done_cnt), 32'd1);
    chk("rescrub.done_at", 32'(done_at), 32'd31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
